// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder.
// Provides the FSM state type, access-size encodings, the latency counter
// width and a small alignment helper used by the top level.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    localparam logic ACC_WORD = 1'b0;
    localparam logic ACC_BYTE = 1'b1;

    localparam int unsigned LAT_W     = 4;
    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = 8;
    localparam int unsigned RAM_W     = NUM_LANES * LANE_W;

    // A word access must sit on a 4-byte boundary; byte accesses never fault.
    function automatic logic is_misaligned(input logic acc, input logic [1:0] lo);
        return (acc == ACC_WORD) && (lo != 2'b00);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request/response bundle between the memory-stage initiator
// (master) and the data memory responder (slave).
//   req_i/we_i/addrSelect_i/addr_i/wd_i : request, held until accepted
//   ready_o                              : responder idle, accepts this edge
//   rvalid_o/rd_o/err_o                  : one-cycle response with data/error
interface data_mem_responder_if #(
    parameter int unsigned DW = 32
);
    logic          req_i;
    logic          we_i;
    logic          addrSelect_i;
    logic [DW-1:0] addr_i;
    logic [DW-1:0] wd_i;
    logic          ready_o;
    logic          rvalid_o;
    logic [DW-1:0] rd_o;
    logic          err_o;

    modport master (
        output req_i, we_i, addrSelect_i, addr_i, wd_i,
        input  ready_o, rvalid_o, rd_o, err_o
    );

    modport slave (
        input  req_i, we_i, addrSelect_i, addr_i, wd_i,
        output ready_o, rvalid_o, rd_o, err_o
    );
endinterface

// File: rtl/data_mem_responder_byte_lane_ram.sv
// Four independent 8-bit lanes forming a 32-bit little-endian data store.
//   clk   : write clock
//   we_i  : per-lane synchronous write enable (bit n writes byte lane n)
//   idx_i : word index (byte address bits AW-1:2)
//   wd_i  : write data, lane n taken from wd_i[8n+7:8n]
//   rd_o  : combinational read of the indexed word
module byte_lane_ram
    import mem_pkg::*;
#(
    parameter int unsigned AW = 16
) (
    input  logic                 clk,
    input  logic [NUM_LANES-1:0] we_i,
    input  logic [AW-3:0]        idx_i,
    input  logic [RAM_W-1:0]     wd_i,
    output logic [RAM_W-1:0]     rd_o
);

    localparam int unsigned DEPTH = 2 ** (AW - 2);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [LANE_W-1:0] mem [DEPTH];

        // Storage is deliberately not reset; contents survive rst.
        always_ff @(posedge clk) begin
            if (we_i[l]) begin
                mem[idx_i] <= wd_i[LANE_W*l +: LANE_W];
            end
        end

        assign rd_o[LANE_W*l +: LANE_W] = mem[idx_i];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the memory-stage load/store interface.
// Accepts one request while idle, waits LATENCY edges, then performs a word
// or zero-extended byte access on the byte-lane store and returns a
// one-cycle rvalid pulse with read data or a misalignment error.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : request/response bundle (slave side)
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 16,
    parameter int unsigned LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    data_mem_responder_if.slave        bus
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("data_mem_responder: LATENCY must be in 1..15");
    end
    if (DW != RAM_W) begin : g_bad_width
        $error("data_mem_responder: DW must equal 32");
    end

    resp_state_t          state_q, state_d;
    logic [LAT_W-1:0]     cnt_q,   cnt_d;
    logic                 we_q,    we_d;
    logic                 sel_q,   sel_d;
    logic [AW-1:0]        addr_q,  addr_d;
    logic [DW-1:0]        wd_q,    wd_d;
    logic                 ready_q, ready_d;
    logic                 rvalid_q, rvalid_d;
    logic [DW-1:0]        rd_q,    rd_d;
    logic                 err_q,   err_d;

    logic [NUM_LANES-1:0] ram_we;
    logic [RAM_W-1:0]     ram_wd;
    logic [RAM_W-1:0]     ram_rdata;
    logic [LANE_W-1:0]    byte_rdata;
    logic                 misaligned;

    // Address bits above AW-1 wrap away by design.
    logic                 unused_addr_hi;
    assign unused_addr_hi = ^bus.addr_i[DW-1:AW];

    byte_lane_ram #(.AW(AW)) u_ram (
        .clk   (clk),
        .we_i  (ram_we),
        .idx_i (addr_q[AW-1:2]),
        .wd_i  (ram_wd),
        .rd_o  (ram_rdata)
    );

    assign misaligned = is_misaligned(sel_q, addr_q[1:0]);
    assign byte_rdata = ram_rdata[{addr_q[1:0], 3'b000} +: LANE_W];

    // Next-state, capture, access and response logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        err_d   = err_q;
        ram_we  = '0;
        ram_wd  = wd_q[RAM_W-1:0];

        case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    we_d    = bus.we_i;
                    sel_d   = bus.addrSelect_i;
                    addr_d  = bus.addr_i[AW-1:0];
                    wd_d    = bus.wd_i;
                    cnt_d   = LAT_W'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - LAT_W'(1);
                end else begin
                    state_d = RESP;
                    if (misaligned) begin
                        rd_d  = '0;
                        err_d = 1'b1;
                    end else if (we_q) begin
                        rd_d  = '0;
                        err_d = 1'b0;
                        if (sel_q == ACC_BYTE) begin
                            // Replicate the byte so whichever lane is enabled sees it.
                            ram_we = NUM_LANES'(1) << addr_q[1:0];
                            ram_wd = {NUM_LANES{wd_q[LANE_W-1:0]}};
                        end else begin
                            ram_we = '1;
                        end
                    end else begin
                        err_d = 1'b0;
                        rd_d  = (sel_q == ACC_BYTE) ? DW'(byte_rdata) : DW'(ram_rdata);
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d  = (state_d == IDLE);
        rvalid_d = (state_d == RESP);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= ACC_WORD;
            addr_q   <= '0;
            wd_q     <= '0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rd_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            wd_q     <= wd_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rd_q     <= rd_d;
            err_q    <= err_d;
        end
    end

    assign bus.ready_o  = ready_q;
    assign bus.rvalid_o = rvalid_q;
    assign bus.rd_o     = rd_q;
    assign bus.err_o    = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: two instances (LATENCY=2 and
// LATENCY=1) checked against a byte-array reference model.
module tb_data_mem_responder;
    import mem_pkg::*;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 16;
    localparam int          LAT0 = 2;
    localparam int          LAT1 = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_responder_if #(.DW(DW)) bus0 ();
    data_mem_responder_if #(.DW(DW)) bus1 ();

    data_mem_responder #(.DW(DW), .AW(AW), .LATENCY(LAT0)) u_dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    data_mem_responder #(.DW(DW), .AW(AW), .LATENCY(LAT1)) u_dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference store: key = instance*65536 + byte address.
    logic [7:0] model [int];

    typedef struct packed {
        logic        we;
        logic        sel;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } op_t;

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    function automatic logic get_ready(input int d);
        return (d == 0) ? bus0.ready_o : bus1.ready_o;
    endfunction

    function automatic logic get_rvalid(input int d);
        return (d == 0) ? bus0.rvalid_o : bus1.rvalid_o;
    endfunction

    function automatic logic [31:0] get_rd(input int d);
        return (d == 0) ? bus0.rd_o : bus1.rd_o;
    endfunction

    function automatic logic get_err(input int d);
        return (d == 0) ? bus0.err_o : bus1.err_o;
    endfunction

    task automatic drive(input int d, input logic req, input logic we, input logic sel,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (d == 0) begin
            bus0.req_i = req; bus0.we_i = we; bus0.addrSelect_i = sel;
            bus0.addr_i = addr; bus0.wd_i = wd;
        end else begin
            bus1.req_i = req; bus1.we_i = we; bus1.addrSelect_i = sel;
            bus1.addr_i = addr; bus1.wd_i = wd;
        end
    endtask

    // Behavioural model of one accepted access.
    function automatic void model_access(input int d, input logic we, input logic sel,
                                         input logic [31:0] addr, input logic [31:0] wd,
                                         output logic [31:0] rd, output logic err,
                                         output logic known);
        int base = d * 65536;
        int a    = int'(addr[15:0]);
        rd = '0; err = 1'b0; known = 1'b1;
        if (!sel && (a % 4) != 0) begin
            err = 1'b1;
            return;
        end
        if (we) begin
            if (sel) model[base + a] = wd[7:0];
            else for (int i = 0; i < 4; i++) model[base + a + i] = wd[8*i +: 8];
        end else if (sel) begin
            if (model.exists(base + a)) rd = {24'd0, model[base + a]};
            else known = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (model.exists(base + a + i)) rd[8*i +: 8] = model[base + a + i];
                else known = 1'b0;
            end
        end
    endfunction

    // Issue one request and observe the response timing. Called #1 after a posedge.
    // lat = edges after accept until rvalid, rdy = edges until ready, pulses = rvalid cycles.
    task automatic access(input int d, input logic we, input logic sel,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err,
                          output int lat, output int rdy, output int pulses);
        int guard = 0;
        lat = -1; rdy = -1; pulses = 0; rd = '0; err = 1'b0;
        while (!get_ready(d) && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        drive(d, 1'b1, we, sel, addr, wd);
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int k = 1; k <= 20 && rdy < 0; k++) begin
            @(posedge clk); #1;
            if (get_rvalid(d)) begin
                pulses++;
                if (lat < 0) begin
                    lat = k; rd = get_rd(d); err = get_err(d);
                end
            end
            if (get_ready(d)) rdy = k;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (get_ready(d) !== 1'b1 || get_rvalid(d) !== 1'b0 ||
                    get_rd(d) !== 32'd0 || get_err(d) !== 1'b0) begin
                    n_fail++;
                    $display("FAIL reset_idle dut%0d cyc%0d: ready=%b rvalid=%b rd=%h err=%b, want 1 0 0 0",
                             d, c, get_ready(d), get_rvalid(d), get_rd(d), get_err(d));
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_directed(input int d);
        op_t ops[$];
        logic [31:0] rd;
        logic err;
        int lat, rdy, pulses;
        logic [31:0] mrd;
        logic merr, known;
        ops.push_back('{1'b1, ACC_WORD, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0});
        ops.push_back('{1'b0, ACC_WORD, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
        ops.push_back('{1'b0, ACC_BYTE, 32'h0000_0011, 32'h0,         32'h0000_00BE, 1'b0});
        ops.push_back('{1'b1, ACC_BYTE, 32'h0000_0012, 32'hFFFF_FFA5, 32'h0, 1'b0});
        ops.push_back('{1'b0, ACC_WORD, 32'h0000_0010, 32'h0,         32'hDEA5_BEEF, 1'b0});
        ops.push_back('{1'b1, ACC_WORD, 32'h0000_0013, 32'h1234_5678, 32'h0, 1'b1});
        ops.push_back('{1'b0, ACC_WORD, 32'h0000_0010, 32'h0,         32'hDEA5_BEEF, 1'b0});
        ops.push_back('{1'b0, ACC_WORD, 32'h0000_0012, 32'h0,         32'h0, 1'b1});
        ops.push_back('{1'b1, ACC_WORD, 32'h0001_0020, 32'h0000_CAFE, 32'h0, 1'b0});
        ops.push_back('{1'b0, ACC_WORD, 32'h0000_0020, 32'h0,         32'h0000_CAFE, 1'b0});
        ops.push_back('{1'b0, ACC_BYTE, 32'hFFFF_0021, 32'h0,         32'h0000_00CA, 1'b0});
        ops.push_back('{1'b1, ACC_WORD, 32'h0000_FFFC, 32'h0102_0304, 32'h0, 1'b0});
        ops.push_back('{1'b0, ACC_BYTE, 32'h0001_FFFF, 32'h0,         32'h0000_0001, 1'b0});
        ops.push_back('{1'b1, ACC_WORD, 32'h0000_0040, 32'h0BAD_F00D, 32'h0, 1'b0});
        foreach (ops[i]) begin
            model_access(d, ops[i].we, ops[i].sel, ops[i].addr, ops[i].wd, mrd, merr, known);
            access(d, ops[i].we, ops[i].sel, ops[i].addr, ops[i].wd, rd, err, lat, rdy, pulses);
            n_checks++;
            if (lat !== lat_of(d) || rdy !== lat_of(d) + 1 || pulses !== 1) begin
                n_fail++;
                $display("FAIL dir_timing dut%0d op%0d: lat=%0d rdy=%0d pulses=%0d, want %0d %0d 1",
                         d, i, lat, rdy, pulses, lat_of(d), lat_of(d) + 1);
            end
            n_checks++;
            if (rd !== ops[i].exp_rd || err !== ops[i].exp_err) begin
                n_fail++;
                $display("FAIL dir_data dut%0d op%0d addr=%h: rd=%h err=%b, want rd=%h err=%b",
                         d, i, ops[i].addr, rd, err, ops[i].exp_rd, ops[i].exp_err);
            end
            n_checks++;
            if (get_rd(d) !== ops[i].exp_rd || get_err(d) !== ops[i].exp_err) begin
                n_fail++;
                $display("FAIL dir_hold dut%0d op%0d: rd=%h err=%b, want rd=%h err=%b",
                         d, i, get_rd(d), get_err(d), ops[i].exp_rd, ops[i].exp_err);
            end
        end
    endtask

    task automatic test_reset_mid(input int d);
        logic [31:0] rd;
        logic err;
        int lat, rdy, pulses;
        int guard = 0;
        int seen = 0;
        while (!get_ready(d) && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        drive(d, 1'b1, 1'b1, ACC_WORD, 32'h0000_0040, 32'h1111_1111);
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (get_rvalid(d) !== 1'b0 || get_ready(d) !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_async dut%0d: rvalid=%b ready=%b, want 0 1", d, get_rvalid(d), get_ready(d));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (get_rvalid(d)) seen++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (seen !== 0 || get_ready(d) !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_no_resp dut%0d: rvalid cycles=%0d ready=%b, want 0 1", d, seen, get_ready(d));
        end
        access(d, 1'b0, ACC_WORD, 32'h0000_0040, 32'd0, rd, err, lat, rdy, pulses);
        n_checks++;
        if (rd !== 32'h0BAD_F00D || err !== 1'b0 || lat !== lat_of(d)) begin
            n_fail++;
            $display("FAIL rst_dropped_store dut%0d: rd=%h err=%b lat=%0d, want 0badf00d 0 %0d",
                     d, rd, err, lat, lat_of(d));
        end
    endtask

    task automatic test_back_to_back(input int d);
        logic [31:0] data [4];
        logic [31:0] addr [4];
        int acc_edge[$];
        int rv_edge[$];
        int idx = 0;
        int guard = 0;
        logic was_ready;
        logic [31:0] rd, mrd;
        logic err, merr, known;
        int lat, rdy, pulses;
        for (int i = 0; i < 4; i++) begin
            data[i] = $urandom;
            addr[i] = 32'h0000_0300 + 32'(4 * i);
        end
        while (!get_ready(d) && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        drive(d, 1'b1, 1'b1, ACC_WORD, addr[0], data[0]);
        for (int e = 1; e <= 60 && (idx < 4 || rv_edge.size() < 4); e++) begin
            was_ready = get_ready(d);
            @(posedge clk); #1;
            if (was_ready && idx < 4) begin
                acc_edge.push_back(e);
                model_access(d, 1'b1, ACC_WORD, addr[idx], data[idx], mrd, merr, known);
                idx++;
                if (idx < 4) drive(d, 1'b1, 1'b1, ACC_WORD, addr[idx], data[idx]);
                else drive(d, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            end
            if (get_rvalid(d)) rv_edge.push_back(e);
        end
        drive(d, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        n_checks++;
        if (acc_edge.size() !== 4 || rv_edge.size() !== 4) begin
            n_fail++;
            $display("FAIL b2b_count dut%0d: accepts=%0d responses=%0d, want 4 4",
                     d, acc_edge.size(), rv_edge.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (rv_edge[i] - acc_edge[i] !== lat_of(d)) begin
                    n_fail++;
                    $display("FAIL b2b_latency dut%0d req%0d: %0d edges, want %0d",
                             d, i, rv_edge[i] - acc_edge[i], lat_of(d));
                end
                if (i > 0) begin
                    // IDLE accept, LATENCY BUSY edges, one RESP edge, then next accept.
                    n_checks++;
                    if (acc_edge[i] - acc_edge[i-1] !== lat_of(d) + 2) begin
                        n_fail++;
                        $display("FAIL b2b_spacing dut%0d req%0d: %0d edges, want %0d",
                                 d, i, acc_edge[i] - acc_edge[i-1], lat_of(d) + 2);
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            access(d, 1'b0, ACC_WORD, addr[i], 32'd0, rd, err, lat, rdy, pulses);
            n_checks++;
            if (rd !== data[i] || err !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_readback dut%0d addr=%h: rd=%h err=%b, want %h 0",
                         d, addr[i], rd, err, data[i]);
            end
        end
    endtask

    task automatic test_random(input int d);
        logic [31:0] rd, mrd, addr, wd;
        logic err, merr, known, we, sel;
        int lat, rdy, pulses;
        for (int i = 0; i < 16; i++) begin
            wd   = $urandom;
            addr = 32'h0000_0200 + 32'(4 * i);
            model_access(d, 1'b1, ACC_WORD, addr, wd, mrd, merr, known);
            access(d, 1'b1, ACC_WORD, addr, wd, rd, err, lat, rdy, pulses);
        end
        for (int i = 0; i < 60; i++) begin
            we   = 1'($urandom_range(0, 1));
            sel  = 1'($urandom_range(0, 1));
            addr = {16'($urandom), 16'h0200 + 16'($urandom_range(0, 63))};
            wd   = $urandom;
            model_access(d, we, sel, addr, wd, mrd, merr, known);
            access(d, we, sel, addr, wd, rd, err, lat, rdy, pulses);
            n_checks++;
            if (lat !== lat_of(d) || pulses !== 1 || err !== merr || (known && rd !== mrd)) begin
                n_fail++;
                $display("FAIL rand dut%0d op%0d we=%b sel=%b addr=%h: rd=%h err=%b lat=%0d, want rd=%h err=%b lat=%0d",
                         d, i, we, sel, addr, rd, err, lat, mrd, merr, lat_of(d));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        for (int d = 0; d < 2; d++) begin
            test_directed(d);
            test_reset_mid(d);
            test_back_to_back(d);
            test_random(d);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
